// File: rtl/mod_n_counter_if.sv
// mod_n_counter_if -- control/status bundle for one modulo-N counter.
//
// Signals
//   en        count enable
//   up_dn     direction: 1 = up, 0 = down
//   clr       synchronous clear to 0
//   load      synchronous parallel load
//   load_val  value to load (WIDTH bits)
//   count     current count, registered (WIDTH bits)
//   tc        terminal count, combinational
//   wrap      one-cycle pulse after a wrap-around edge
//   load_err  one-cycle pulse after an out-of-range load
//
// Modports
//   master  drives the controls and observes the status (the user side)
//   slave   the counter itself
interface mod_n_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/mod_n_counter.sv
// mod_n_counter -- up/down modulo-MODULUS counter with clear, parallel load,
// terminal-count, wrap pulse and out-of-range load flag.
//
// Parameters
//   WIDTH    count register width in bits (must match the interface WIDTH)
//   MODULUS  number of count states, 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mod_n_counter_if.slave: en, up_dn, clr, load, load_val in;
//          count, tc, wrap, load_err out
//
// Priority on each edge: clr > load > en > hold. tc is combinational so it
// can feed the en of a following stage on the same clock.
module mod_n_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    mod_n_counter_if.slave  bus
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("mod_n_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             at_max, at_zero;

    assign at_max  = (count_q == MAX_C);
    assign at_zero = (count_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    // Pulses default low every edge, so a pulse lasts exactly one cycle and
    // clr/load suppress wrap even when the counter is at terminal count.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.clr) begin
            count_d = '0;
        end else if (bus.load) begin
            // Out-of-range loads saturate to the top state and are flagged.
            if (32'(bus.load_val) >= MODULUS) begin
                count_d    = MAX_C;
                load_err_d = 1'b1;
            end else begin
                count_d = bus.load_val;
            end
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (at_max) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    count_d = MAX_C;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = bus.en & (bus.up_dn ? at_max : at_zero);
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: WIDTH=3, MODULUS=6
    mod_n_counter_if #(.WIDTH(3)) m6_if ();
    mod_n_counter #(.WIDTH(3), .MODULUS(6)) u_m6 (.clk(clk), .rst_n(rst_n), .bus(m6_if));

    // Power-of-two modulus: WIDTH=3, MODULUS=8
    mod_n_counter_if #(.WIDTH(3)) m8_if ();
    mod_n_counter #(.WIDTH(3), .MODULUS(8)) u_m8 (.clk(clk), .rst_n(rst_n), .bus(m8_if));

    // Cascade: low MODULUS=6, high MODULUS=10 enabled by low tc
    mod_n_counter_if #(.WIDTH(3)) lo_if ();
    mod_n_counter_if #(.WIDTH(4)) hi_if ();
    mod_n_counter #(.WIDTH(3), .MODULUS(6))  u_lo (.clk(clk), .rst_n(rst_n), .bus(lo_if));
    mod_n_counter #(.WIDTH(4), .MODULUS(10)) u_hi (.clk(clk), .rst_n(rst_n), .bus(hi_if));
    assign hi_if.en = lo_if.tc;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    typedef struct packed {
        logic       clr;
        logic       load;
        logic       en;
        logic       up_dn;
        logic [2:0] load_val;
        logic [2:0] count;
        logic       wrap;
        logic       load_err;
        logic       tc;
    } vec_t;

    function automatic vec_t mk(input int c, input int l, input int e, input int u, input int lv,
                                input int cnt, input int w, input int le, input int t);
        vec_t v;
        v.clr      = c[0];
        v.load     = l[0];
        v.en       = e[0];
        v.up_dn    = u[0];
        v.load_val = lv[2:0];
        v.count    = cnt[2:0];
        v.wrap     = w[0];
        v.load_err = le[0];
        v.tc       = t[0];
        return v;
    endfunction

    vec_t vecs[23];

    task automatic drive_m6(input logic c, input logic l, input logic e, input logic u, input logic [2:0] lv);
        m6_if.clr      = c;
        m6_if.load     = l;
        m6_if.en       = e;
        m6_if.up_dn    = u;
        m6_if.load_val = lv;
    endtask

    initial begin
        // fields: clr load en up load_val | count wrap load_err tc (sampled after edge)
        vecs[0]  = mk(0,0,1,1,0, 1,0,0,0);
        vecs[1]  = mk(0,0,1,1,0, 2,0,0,0);
        vecs[2]  = mk(0,0,1,1,0, 3,0,0,0);
        vecs[3]  = mk(0,0,1,1,0, 4,0,0,0);
        vecs[4]  = mk(0,0,1,1,0, 5,0,0,1);
        vecs[5]  = mk(0,0,1,1,0, 0,1,0,0);
        vecs[6]  = mk(0,0,1,1,0, 1,0,0,0);
        vecs[7]  = mk(0,0,1,1,0, 2,0,0,0);
        vecs[8]  = mk(0,0,1,0,0, 1,0,0,0);
        vecs[9]  = mk(0,0,1,0,0, 0,0,0,1);
        vecs[10] = mk(0,0,1,0,0, 5,1,0,0);
        vecs[11] = mk(0,0,1,0,0, 4,0,0,0);
        vecs[12] = mk(0,0,0,0,0, 4,0,0,0);
        vecs[13] = mk(0,0,1,1,0, 5,0,0,1);
        vecs[14] = mk(0,1,1,1,4, 4,0,0,0);
        vecs[15] = mk(0,1,0,0,7, 5,0,1,0);
        vecs[16] = mk(0,0,0,0,0, 5,0,0,0);
        vecs[17] = mk(1,1,1,1,3, 0,0,0,0);
        vecs[18] = mk(0,1,0,1,6, 5,0,1,0);
        vecs[19] = mk(1,0,1,1,0, 0,0,0,0);
        vecs[20] = mk(0,0,1,0,0, 5,1,0,0);
        vecs[21] = mk(0,0,1,1,0, 0,1,0,0);
        vecs[22] = mk(0,0,1,1,0, 1,0,0,0);

        rst_n = 1'b0;
        drive_m6(0, 0, 0, 1, 3'd0);
        m8_if.clr = 0; m8_if.load = 0; m8_if.en = 0; m8_if.up_dn = 1; m8_if.load_val = '0;
        lo_if.clr = 0; lo_if.load = 0; lo_if.en = 0; lo_if.up_dn = 1; lo_if.load_val = '0;
        hi_if.clr = 0; hi_if.load = 0; hi_if.up_dn = 1; hi_if.load_val = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_count", int'(m6_if.count), 0);
        check("reset_wrap", int'(m6_if.wrap), 0);
        check("reset_load_err", int'(m6_if.load_err), 0);
        check("reset_tc", int'(m6_if.tc), 0);

        // Table-driven main function
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive_m6(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up_dn, vecs[i].load_val);
            @(posedge clk);
            #1;
            $display("vec %0d: clr=%0d load=%0d en=%0d up=%0d lv=%0d -> count=%0d wrap=%0d err=%0d tc=%0d",
                     i, vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up_dn, vecs[i].load_val,
                     m6_if.count, m6_if.wrap, m6_if.load_err, m6_if.tc);
            check($sformatf("vec%0d_count", i), int'(m6_if.count), int'(vecs[i].count));
            check($sformatf("vec%0d_wrap", i), int'(m6_if.wrap), int'(vecs[i].wrap));
            check($sformatf("vec%0d_load_err", i), int'(m6_if.load_err), int'(vecs[i].load_err));
            check($sformatf("vec%0d_tc", i), int'(m6_if.tc), int'(vecs[i].tc));
        end

        // Async reset at count=5 with a wrap pending
        @(negedge clk);
        drive_m6(0, 1, 0, 1, 3'd5);
        @(posedge clk);
        #1;
        check("pre_rst_count", int'(m6_if.count), 5);
        @(negedge clk);
        drive_m6(0, 0, 1, 1, 3'd0);
        #1;
        check("pre_rst_tc", int'(m6_if.tc), 1);
        rst_n = 1'b0;
        #1;
        $display("async reset mid-cycle: count=%0d wrap=%0d", m6_if.count, m6_if.wrap);
        check("async_rst_count", int'(m6_if.count), 0);
        check("async_rst_wrap", int'(m6_if.wrap), 0);
        drive_m6(0, 1, 1, 1, 3'd3);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ignores_ctrl_count", int'(m6_if.count), 0);
        @(negedge clk);
        drive_m6(0, 0, 0, 1, 3'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_count", int'(m6_if.count), 0);
        @(posedge clk);
        #1;
        $display("after reset release: count=%0d wrap=%0d", m6_if.count, m6_if.wrap);
        check("no_wrap_after_rst", int'(m6_if.wrap), 0);
        check("hold_after_rst", int'(m6_if.count), 0);

        // Async reset aborts a load_err pulse
        @(negedge clk);
        drive_m6(0, 1, 0, 1, 3'd7);
        @(posedge clk);
        #1;
        check("err_pulse_before_rst", int'(m6_if.load_err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset on load_err: count=%0d load_err=%0d", m6_if.count, m6_if.load_err);
        check("rst_aborts_load_err", int'(m6_if.load_err), 0);
        check("rst_aborts_count", int'(m6_if.count), 0);
        @(negedge clk);
        drive_m6(0, 0, 0, 1, 3'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("err_stays_low", int'(m6_if.load_err), 0);

        // MODULUS = 2**WIDTH natural roll-over
        begin
            int exp8[9];
            exp8 = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
            @(negedge clk);
            m8_if.en = 1; m8_if.up_dn = 1;
            for (int i = 0; i < 9; i++) begin
                @(posedge clk);
                #1;
                $display("m8 edge %0d: count=%0d wrap=%0d", i, m8_if.count, m8_if.wrap);
                check($sformatf("m8_count%0d", i), int'(m8_if.count), exp8[i]);
                check($sformatf("m8_wrap%0d", i), int'(m8_if.wrap), (i == 7) ? 1 : 0);
            end
            @(negedge clk);
            m8_if.en = 0;
        end

        // Cascade 6 x 10 -> 0..59 then roll-over
        @(negedge clk);
        lo_if.en = 1; lo_if.up_dn = 1;
        for (int k = 0; k < 60; k++) begin
            int got;
            @(posedge clk);
            #1;
            got = int'(hi_if.count) * 6 + int'(lo_if.count);
            $display("cascade edge %0d: hi=%0d lo=%0d combined=%0d", k, hi_if.count, lo_if.count, got);
            check($sformatf("cascade%0d", k), got, (k + 1) % 60);
        end
        check("cascade_hi_wrap", int'(hi_if.wrap), 1);
        @(negedge clk);
        lo_if.en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_n_counter.md
MOD_N_COUNTER -- requirements
Module: mod_n_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 3, the count register width in bits.
REQ-002 SHALL provide parameter MODULUS, default 6, the number of count states (0..MODULUS-1).
REQ-003 SHALL accept only 2 <= MODULUS <= 2**WIDTH; any other value SHALL be an elaboration error.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  count enable.
REQ-007 up_dn  input  1  direction: 1 = count up, 0 = count down.
REQ-008 clr  input  1  synchronous clear to 0.
REQ-009 load  input  1  synchronous parallel load.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 count  output  WIDTH  current count, registered.
REQ-012 tc  output  1  terminal count, combinational: en & (up_dn ? count==MODULUS-1 : count==0).
REQ-013 wrap  output  1  registered one-cycle pulse: count wrapped on the previous edge.
REQ-014 load_err  output  1  registered one-cycle pulse: previous load had load_val >= MODULUS.

Function
REQ-015 SHALL update count on each rising clk edge with priority clr > load > en > hold.
REQ-016 clr=1: count SHALL become 0; wrap and load_err SHALL be 0 on that edge.
REQ-017 load=1, clr=0, load_val < MODULUS: count SHALL become load_val, load_err 0.
REQ-018 load=1, clr=0, load_val >= MODULUS: count SHALL become MODULUS-1 and load_err SHALL be 1 for exactly one cycle.
REQ-019 en=1, up_dn=1, count < MODULUS-1: count SHALL increment by 1.
REQ-020 en=1, up_dn=1, count == MODULUS-1: count SHALL become 0 and wrap SHALL be 1 on the following cycle only.
REQ-021 en=1, up_dn=0, count > 0: count SHALL decrement by 1.
REQ-022 en=1, up_dn=0, count == 0: count SHALL become MODULUS-1 and wrap SHALL be 1 on the following cycle only.
REQ-023 en=0 with no clr or load: count SHALL hold; wrap SHALL be 0.
REQ-024 wrap SHALL be 0 on any edge where clr or load is asserted, even if en=1 and tc=1.
REQ-025 count SHALL never leave the range 0..MODULUS-1 after reset, including MODULUS = 2**WIDTH (natural roll-over).
REQ-026 A direction change SHALL take effect on the same edge it is sampled; no settling cycle.
REQ-027 tc SHALL be usable as en of a cascaded instance on the same clk (synchronous cascade; no derived clocks).
REQ-028 All flops SHALL be clocked by clk only; no output or internal state SHALL be used as a clock.

Reset
REQ-029 rst=0 SHALL immediately, regardless of clk, force count=0, wrap=0, load_err=0.
REQ-030 While rst=0, clr, load and en SHALL be ignored.
REQ-031 Deassertion of rst SHALL be synchronous-safe; the first count change SHALL occur no earlier than the first rising clk edge after rst rises.
REQ-032 rst asserted mid-count SHALL abort any pending wrap or load_err pulse.

Verification (WIDTH=3, MODULUS=6 unless stated)
REQ-033 Reset, then en=1, up_dn=1 for 8 edges -> count 1,2,3,4,5,0,1,2; wrap=1 only in the cycle after 5->0; tc=1 only while count=5.
REQ-034 From count=2, up_dn=0 for 4 edges -> count 1,0,5,4; wrap pulses once after 0->5.
REQ-035 load=1, load_val=4 -> count=4, load_err=0; then load_val=7 -> count=5, load_err=1 for one cycle; clr=1 and load=1 together -> count=0.
REQ-036 count=5, en=1, up_dn=1, drive rst=0 between clock edges -> count=0, wrap=0 immediately; no wrap pulse after rst returns to 1.
REQ-037 WIDTH=3, MODULUS=8 up-count for 9 edges -> 1..7,0,1; wrap after 7->0; two instances cascaded via tc (MODULUS=6 low, 10 high) -> combined range 0..59 and roll-over to 0.
